control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit that replaces hand-sequenced bench control. It fetches, decodes and steps each instruction through T0..T7, driving every control input of `datapath`.
- Generalises the fixed load sequence to these classes: load (LD), load-immediate (LDI), store (ST), register ALU ops, MUL/DIV with HI/LO writeback, and HALT.
- Adds parametrised memory wait-stretching and fault detection.
- Sits beside `datapath`; its `ctrl` bus connects bit-for-bit to the datapath control inputs.

Parameters:
- MEM_WAIT, 0, extra cycles each memory step (read or write) is held before advancing (0..15).
- CTRL_W, 28, width of the control bus (package constant, not to be overridden).

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous, active-high reset.
- run  in  1  level; sequencer leaves IDLE / continues to next fetch while high.
- ir_q  in  32  current IR contents from datapath; opcode [31:27], ra [26:23], rb [22:19], rc [18:15].
- ctrl  out  CTRL_W  datapath control strobes, indices from package.
- alu_op  out  5  ALU opcode to datapath.
- step_q  out  4  current state encoding (debug).
- done  out  1  one-cycle pulse in the final step of each instruction.
- fault  out  1  sticky; illegal opcode decoded.
- halted  out  1  sticky; HALT executed.

Behaviour:
- Reset (clr high, asynchronous):
  - state = IDLE, wait counter = 0.
  - ctrl = 0, alu_op = 0 (nop), done = fault = halted = 0.
  - Outputs drop immediately, including mid-instruction; no partial step completes.
- Outputs are Moore: decoded combinationally from the state register and latched opcode only. alu_op = nop whenever Zin is low.
- States: IDLE, T0..T7, HALT, FAULT.
  - IDLE->T0 on the edge where run=1.
  - After the final step: ->T0 if run=1, else IDLE.
- Fetch (all classes):
  - T0: PCout, MARin, incPC, Zin.
  - T1: ZLowOut, PCin, read, MDRin (memory step).
  - T2: MDRout, IRin.
  - Opcode is latched from ir_q at the end of T2.
- Common address phase, for LD / LDI / ST:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin, alu_op = ADD.
- LD: T5 ZLowOut, MARin; T6 read, MDRin (memory step); T7 MDRout, Gra, Rin, done.
- LDI: T5 ZLowOut, Gra, Rin, done.
- ST: T5 ZLowOut, MARin; T6 Gra, Rout, MDRin; T7 write, done (memory step).
- ALU ops (opcodes 00001..01111 except MUL/DIV):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op = opcode.
  - T5: ZLowOut, Gra, Rin, done.
- MUL (00011) / DIV (00100): T3 and T4 as ALU ops; T5 ZLowOut, LOin; T6 ZHighOut, HIin, done.
- HALT (11011): T2->HALT; halted=1, ctrl=0; exit only on clr.
- Any other opcode: T2->FAULT; fault=1, ctrl=0; exit only on clr.
- Memory steps: state holds for MEM_WAIT+1 cycles with ctrl held constant. The counter reloads on entry to each memory step.
- done asserts only in the last cycle of a stretched step.
- run falling mid-instruction has no effect; the instruction completes, then the sequencer goes to IDLE.

Optional Feature:
- Macro: CTRL_SINGLE_STEP_EN.
- When defined:
  - Adds input `step` (1 bit). Every state transition other than reset, including IDLE->T0, additionally requires step=1 on that edge.
  - Memory wait counting is paused while step=0.
- When undefined: no `step` port; advancement is as in Behaviour.

Decomposition:
- Package `cpu_ctrl_pkg`:
  - CTRL_W = 28 and one index constant per control bit, in order: read, write, BAout, Rin, Rout, Gra, Grb, Grc, CONN_in, MARin, MDRin, HIin, LOin, Yin, Zin, PCin, IRin, incPC, InPortIn, OutPortIn, HIout, LOout, ZHighOut, ZLowOut, MDRout, PCout, InPortOut, Cout.
  - Opcode constants: nop..log_not = 00000..01111, OP_LD 10000, OP_LDI 10001, OP_ST 10010, OP_HALT 11011.
  - State encodings.
- One sub-module, `ctrl_decode`: a purely combinational map of (state, opcode) -> ctrl/alu_op/done/last-step. The top holds the state register and wait counter.

Test Plan:
- MEM_WAIT=0, run=1, ir_q=0x80800075 (ld R1,0x75(R0)) -> T0..T7 each exactly one cycle; T4 alu_op=00001; T7 has MDRout, Gra, Rin and done; then T0 again.
- ir_q=0x09890000 (add R3,R1,R2) -> T5 asserts ZLowOut, Gra, Rin and done; the instruction never enters T6; T4 alu_op=00001 with Grc, Rout, Zin.
- MEM_WAIT=2, ST with ir_q=0x90800075 -> T1 and T7 each last 3 cycles with write steady in T7; done only in the third T7 cycle.
- MUL ir_q=0x19890000 -> T5 LOin and ZLowOut, T6 HIin and ZHighOut, done in T6.
- ir_q=0xF8000000 -> fault=1 and ctrl=0 after T2, held for 20 cycles. ir_q=0xD8000000 -> halted=1 held. clr pulse clears both, state returns to IDLE.
- Assert clr asynchronously mid-T4 -> ctrl=0 and step_q=IDLE before the next clk edge. With CTRL_SINGLE_STEP_EN defined and step=0, the state holds indefinitely.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired control sequencer:
// control-bus bit indices, opcodes, state encodings and class helpers.
package cpu_ctrl_pkg;

    localparam int CTRL_W = 28;

    localparam int C_READ      = 0;
    localparam int C_WRITE     = 1;
    localparam int C_BAOUT     = 2;
    localparam int C_RIN       = 3;
    localparam int C_ROUT      = 4;
    localparam int C_GRA       = 5;
    localparam int C_GRB       = 6;
    localparam int C_GRC       = 7;
    localparam int C_CONN_IN   = 8;
    localparam int C_MARIN     = 9;
    localparam int C_MDRIN     = 10;
    localparam int C_HIIN      = 11;
    localparam int C_LOIN      = 12;
    localparam int C_YIN       = 13;
    localparam int C_ZIN       = 14;
    localparam int C_PCIN      = 15;
    localparam int C_IRIN      = 16;
    localparam int C_INCPC     = 17;
    localparam int C_INPORTIN  = 18;
    localparam int C_OUTPORTIN = 19;
    localparam int C_HIOUT     = 20;
    localparam int C_LOOUT     = 21;
    localparam int C_ZHIGHOUT  = 22;
    localparam int C_ZLOWOUT   = 23;
    localparam int C_MDROUT    = 24;
    localparam int C_PCOUT     = 25;
    localparam int C_INPORTOUT = 26;
    localparam int C_COUT      = 27;

    localparam logic [4:0] OP_NOP     = 5'b00000;
    localparam logic [4:0] OP_ADD     = 5'b00001;
    localparam logic [4:0] OP_SUB     = 5'b00010;
    localparam logic [4:0] OP_MUL     = 5'b00011;
    localparam logic [4:0] OP_DIV     = 5'b00100;
    localparam logic [4:0] OP_LOG_NOT = 5'b01111;
    localparam logic [4:0] OP_LD      = 5'b10000;
    localparam logic [4:0] OP_LDI     = 5'b10001;
    localparam logic [4:0] OP_ST      = 5'b10010;
    localparam logic [4:0] OP_HALT    = 5'b11011;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_T0    = 4'd1;
    localparam logic [3:0] S_T1    = 4'd2;
    localparam logic [3:0] S_T2    = 4'd3;
    localparam logic [3:0] S_T3    = 4'd4;
    localparam logic [3:0] S_T4    = 4'd5;
    localparam logic [3:0] S_T5    = 4'd6;
    localparam logic [3:0] S_T6    = 4'd7;
    localparam logic [3:0] S_T7    = 4'd8;
    localparam logic [3:0] S_HALT  = 4'd9;
    localparam logic [3:0] S_FAULT = 4'd10;

    function automatic logic op_is_alu(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_LOG_NOT);
    endfunction

    function automatic logic op_legal(input logic [4:0] op);
        return op_is_alu(op) || (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    endfunction

    // Steps that touch memory and are stretched by the wait counter.
    function automatic logic is_mem_step(input logic [3:0] s, input logic [4:0] op);
        return (s == S_T1) || (s == S_T6 && op == OP_LD) || (s == S_T7 && op == OP_ST);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map of (state, latched opcode) to control strobes,
// ALU opcode, done, final-step and memory-step flags.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0]        i_state,
    input  logic [4:0]        i_opc,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [4:0]        o_alu_op,
    output logic              o_done,
    output logic              o_last,
    output logic              o_mem
);

    logic w_ld;
    logic w_ldi;
    logic w_st;
    logic w_addr;
    logic w_md;

    assign w_ld   = (i_opc == OP_LD);
    assign w_ldi  = (i_opc == OP_LDI);
    assign w_st   = (i_opc == OP_ST);
    assign w_addr = w_ld || w_ldi || w_st;
    assign w_md   = (i_opc == OP_MUL) || (i_opc == OP_DIV);
    assign o_mem  = is_mem_step(i_state, i_opc);

    always_comb begin
        o_ctrl   = '0;
        o_alu_op = OP_NOP;
        o_done   = 1'b0;
        o_last   = 1'b0;
        case (i_state)
            S_T0: begin
                o_ctrl[C_PCOUT] = 1'b1;
                o_ctrl[C_MARIN] = 1'b1;
                o_ctrl[C_INCPC] = 1'b1;
                o_ctrl[C_ZIN]   = 1'b1;
            end
            S_T1: begin
                o_ctrl[C_ZLOWOUT] = 1'b1;
                o_ctrl[C_PCIN]    = 1'b1;
                o_ctrl[C_READ]    = 1'b1;
                o_ctrl[C_MDRIN]   = 1'b1;
            end
            S_T2: begin
                o_ctrl[C_MDROUT] = 1'b1;
                o_ctrl[C_IRIN]   = 1'b1;
            end
            S_T3: begin
                o_ctrl[C_GRB] = 1'b1;
                o_ctrl[C_YIN] = 1'b1;
                if (w_addr) o_ctrl[C_BAOUT] = 1'b1;
                else        o_ctrl[C_ROUT]  = 1'b1;
            end
            S_T4: begin
                o_ctrl[C_ZIN] = 1'b1;
                if (w_addr) begin
                    o_ctrl[C_COUT] = 1'b1;
                    o_alu_op       = OP_ADD;
                end else begin
                    o_ctrl[C_GRC]  = 1'b1;
                    o_ctrl[C_ROUT] = 1'b1;
                    o_alu_op       = i_opc;
                end
            end
            S_T5: begin
                o_ctrl[C_ZLOWOUT] = 1'b1;
                unique case (1'b1)
                    w_ld, w_st: o_ctrl[C_MARIN] = 1'b1;
                    w_md:       o_ctrl[C_LOIN]  = 1'b1;
                    default: begin
                        o_ctrl[C_GRA] = 1'b1;
                        o_ctrl[C_RIN] = 1'b1;
                        o_done        = 1'b1;
                        o_last        = 1'b1;
                    end
                endcase
            end
            S_T6: begin
                unique case (1'b1)
                    w_ld: begin
                        o_ctrl[C_READ]  = 1'b1;
                        o_ctrl[C_MDRIN] = 1'b1;
                    end
                    w_st: begin
                        o_ctrl[C_GRA]   = 1'b1;
                        o_ctrl[C_ROUT]  = 1'b1;
                        o_ctrl[C_MDRIN] = 1'b1;
                    end
                    default: begin
                        o_ctrl[C_ZHIGHOUT] = 1'b1;
                        o_ctrl[C_HIIN]     = 1'b1;
                        o_done             = 1'b1;
                        o_last             = 1'b1;
                    end
                endcase
            end
            S_T7: begin
                o_done = 1'b1;
                o_last = 1'b1;
                if (w_st) begin
                    o_ctrl[C_WRITE] = 1'b1;
                end else begin
                    o_ctrl[C_MDROUT] = 1'b1;
                    o_ctrl[C_GRA]    = 1'b1;
                    o_ctrl[C_RIN]    = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T0..T7 control sequencer with memory wait-stretching.
// Optional single-step gating via CTRL_SINGLE_STEP_EN.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              run,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic              step,
`endif
    input  logic [31:0]       ir_q,
    output logic [CTRL_W-1:0] ctrl,
    output logic [4:0]        alu_op,
    output logic [3:0]        step_q,
    output logic              done,
    output logic              fault,
    output logic              halted
);

    logic [3:0] r_state;
    logic [3:0] r_wait;
    logic [4:0] r_opc;
    logic [3:0] w_next;
    logic [4:0] w_ir_op;
    logic       w_adv;
    logic       w_hold;
    logic       w_mem;
    logic       w_last;
    logic       w_done_raw;
    logic       w_unused;

    assign w_ir_op  = ir_q[31:27];
    assign w_unused = ^ir_q[26:0];

`ifdef CTRL_SINGLE_STEP_EN
    assign w_adv = step;
`else
    assign w_adv = 1'b1;
`endif

    ctrl_decode u_dec (
        .i_state  (r_state),
        .i_opc    (r_opc),
        .o_ctrl   (ctrl),
        .o_alu_op (alu_op),
        .o_done   (w_done_raw),
        .o_last   (w_last),
        .o_mem    (w_mem)
    );

    assign w_hold = w_mem && (r_wait != 4'd0);
    assign done   = w_done_raw && !w_hold;
    assign step_q = r_state;
    assign fault  = (r_state == S_FAULT);
    assign halted = (r_state == S_HALT);

    always_comb begin
        w_next = r_state;
        if (w_adv && !w_hold) begin
            case (r_state)
                S_IDLE: if (run) w_next = S_T0;
                S_T2: begin
                    if (w_ir_op == OP_HALT)     w_next = S_HALT;
                    else if (!op_legal(w_ir_op)) w_next = S_FAULT;
                    else                         w_next = S_T3;
                end
                S_HALT, S_FAULT: w_next = r_state;
                default: begin
                    if (w_last) w_next = run ? S_T0 : S_IDLE;
                    else        w_next = r_state + 4'd1;
                end
            endcase
        end
    end

    // Counter reloads on every advance so each memory step starts full.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_wait  <= 4'd0;
            r_opc   <= OP_NOP;
        end else begin
            r_state <= w_next;
            if (w_adv) begin
                if (w_hold) r_wait <= r_wait - 4'd1;
                else        r_wait <= 4'(MEM_WAIT);
            end
            if (r_state == S_T2 && w_adv) r_opc <= w_ir_op;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch/execute sequences,
// wait stretching, fault/halt, and asynchronous reset.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              clr = 1'b1;
    logic              run = 1'b0;
    logic [31:0]       ir_q = 32'h8080_0075;
`ifdef CTRL_SINGLE_STEP_EN
    logic              step = 1'b1;
`endif
    logic [CTRL_W-1:0] ctrl0, ctrl2;
    logic [4:0]        alu0, alu2;
    logic [3:0]        st0, st2;
    logic              done0, done2, fault0, fault2, halt0, halt2;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    control_sequencer #(.MEM_WAIT(0)) u0 (
        .clk(clk), .clr(clr), .run(run),
`ifdef CTRL_SINGLE_STEP_EN
        .step(step),
`endif
        .ir_q(ir_q), .ctrl(ctrl0), .alu_op(alu0), .step_q(st0),
        .done(done0), .fault(fault0), .halted(halt0)
    );

    control_sequencer #(.MEM_WAIT(2)) u2 (
        .clk(clk), .clr(clr), .run(run),
`ifdef CTRL_SINGLE_STEP_EN
        .step(step),
`endif
        .ir_q(ir_q), .ctrl(ctrl2), .alu_op(alu2), .step_q(st2),
        .done(done2), .fault(fault2), .halted(halt2)
    );

    function automatic logic [31:0] b(input int i);
        return 32'd1 << i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_state", 32'(st0), 32'(S_IDLE));
        chk("rst_ctrl", 32'(ctrl0), 0);
        chk("rst_alu", 32'(alu0), 0);
        chk("rst_flags", {done0, fault0, halt0}, 0);
        clr = 1'b0;
        tick();
        chk("idle_hold", 32'(st0), 32'(S_IDLE));

        // LD with no wait states
        run = 1'b1;
        tick();
        chk("ld_t0_st", 32'(st0), 32'(S_T0));
        chk("ld_t0", 32'(ctrl0), b(C_PCOUT) | b(C_MARIN) | b(C_INCPC) | b(C_ZIN));
        tick();
        chk("ld_t1", 32'(ctrl0), b(C_ZLOWOUT) | b(C_PCIN) | b(C_READ) | b(C_MDRIN));
        tick();
        chk("ld_t2", 32'(ctrl0), b(C_MDROUT) | b(C_IRIN));
        tick();
        chk("ld_t3", 32'(ctrl0), b(C_GRB) | b(C_BAOUT) | b(C_YIN));
        tick();
        chk("ld_t4", 32'(ctrl0), b(C_COUT) | b(C_ZIN));
        chk("ld_t4_alu", 32'(alu0), 32'h1);
        tick();
        chk("ld_t5", 32'(ctrl0), b(C_ZLOWOUT) | b(C_MARIN));
        tick();
        chk("ld_t6", 32'(ctrl0), b(C_READ) | b(C_MDRIN));
        chk("ld_t6_done", 32'(done0), 0);
        tick();
        chk("ld_t7_st", 32'(st0), 32'(S_T7));
        chk("ld_t7", 32'(ctrl0), b(C_MDROUT) | b(C_GRA) | b(C_RIN));
        chk("ld_t7_done", 32'(done0), 1);
        tick();
        chk("ld_next_t0", 32'(st0), 32'(S_T0));

        // ADD; run drops mid-instruction
        ir_q = 32'h0989_0000;
        restart();
        tick(); tick(); tick(); tick();
        chk("add_t3", 32'(ctrl0), b(C_GRB) | b(C_ROUT) | b(C_YIN));
        run = 1'b0;
        tick();
        chk("add_t4", 32'(ctrl0), b(C_GRC) | b(C_ROUT) | b(C_ZIN));
        chk("add_t4_alu", 32'(alu0), 32'h1);
        tick();
        chk("add_t5_st", 32'(st0), 32'(S_T5));
        chk("add_t5", 32'(ctrl0), b(C_ZLOWOUT) | b(C_GRA) | b(C_RIN));
        chk("add_t5_done", 32'(done0), 1);
        tick();
        chk("add_idle", 32'(st0), 32'(S_IDLE));
        chk("add_idle_done", 32'(done0), 0);

        // ST with MEM_WAIT=2 on u2
        ir_q = 32'h9080_0075;
        run = 1'b1;
        restart();
        tick();
        chk("st_t0", 32'(st2), 32'(S_T0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_t1_hold", 32'(st2), 32'(S_T1));
        end
        tick();
        chk("st_t2", 32'(st2), 32'(S_T2));
        tick(); tick(); tick();
        chk("st_t5", 32'(ctrl2), b(C_ZLOWOUT) | b(C_MARIN));
        tick();
        chk("st_t6", 32'(ctrl2), b(C_GRA) | b(C_ROUT) | b(C_MDRIN));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_t7_st", 32'(st2), 32'(S_T7));
            chk("st_t7", 32'(ctrl2), b(C_WRITE));
            chk("st_t7_done", 32'(done2), (i == 2) ? 32'd1 : 32'd0);
        end
        tick();
        chk("st_next_t0", 32'(st2), 32'(S_T0));

        // MUL
        ir_q = 32'h1989_0000;
        restart();
        tick(); tick(); tick(); tick(); tick();
        chk("mul_t4_alu", 32'(alu0), 32'h3);
        tick();
        chk("mul_t5", 32'(ctrl0), b(C_LOIN) | b(C_ZLOWOUT));
        chk("mul_t5_done", 32'(done0), 0);
        tick();
        chk("mul_t6", 32'(ctrl0), b(C_HIIN) | b(C_ZHIGHOUT));
        chk("mul_t6_done", 32'(done0), 1);

        // Illegal opcode
        ir_q = 32'hF800_0000;
        restart();
        tick(); tick(); tick(); tick();
        chk("flt_state", 32'(st0), 32'(S_FAULT));
        chk("flt_set", 32'(fault0), 1);
        for (int i = 0; i < 20; i++) tick();
        chk("flt_held", 32'(fault0), 1);
        chk("flt_ctrl", 32'(ctrl0), 0);
        clr = 1'b1;
        #1;
        chk("flt_clr", 32'(fault0), 0);
        chk("flt_clr_st", 32'(st0), 32'(S_IDLE));

        // HALT
        ir_q = 32'hD800_0000;
        tick();
        clr = 1'b0;
        tick(); tick(); tick(); tick();
        chk("hlt_set", 32'(halt0), 1);
        for (int i = 0; i < 5; i++) tick();
        chk("hlt_held", 32'(st0), 32'(S_HALT));
        chk("hlt_ctrl", 32'(ctrl0), 0);
        clr = 1'b1;
        #1;
        chk("hlt_clr", 32'(halt0), 0);
        tick();
        clr = 1'b0;

        // Async clear mid-T4
        ir_q = 32'h8080_0075;
        restart();
        tick(); tick(); tick(); tick(); tick();
        chk("ar_t4", 32'(st0), 32'(S_T4));
        #2;
        clr = 1'b1;
        #1;
        chk("ar_ctrl", 32'(ctrl0), 0);
        chk("ar_alu", 32'(alu0), 0);
        chk("ar_state", 32'(st0), 32'(S_IDLE));
        tick();
        clr = 1'b0;

`ifdef CTRL_SINGLE_STEP_EN
        step = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("ss_idle", 32'(st0), 32'(S_IDLE));
        step = 1'b1;
        tick();
        chk("ss_t0", 32'(st0), 32'(S_T0));
        step = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("ss_hold", 32'(st0), 32'(S_T0));
        step = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
